// File: rtl/smol_decode.sv
// smolCore decode/operand-issue stage: RV32I decode, immediate build, 32x32 register
// file with writeback bypass, and a registered, stall-able issue bundle toward execute.
module smol_decode #(
  parameter int unsigned     PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_PC_OUT = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [31:0]     wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      op_sel,
  output logic [31:0]     rs1_val,
  output logic [31:0]     rs2_val,
  output logic [31:0]     rs2_or_imm,
  output logic [31:0]     imm,
  output logic [4:0]      rd,
  output logic            reg_we,
  output logic            is_load,
  output logic            is_store,
  output logic            is_branch,
  output logic            is_jal,
  output logic            is_jalr,
  output logic [2:0]      funct3,
  output logic            illegal,
  output logic [PC_W-1:0] out_pc
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned OP_W   = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [OP_W-1:0] ALU_SUB  = 5'd1;
  localparam logic [OP_W-1:0] ALU_SLL  = 5'd6;
  localparam logic [OP_W-1:0] ALU_SRL  = 5'd5;
  localparam logic [OP_W-1:0] ALU_LUI  = 5'd8;
  localparam logic [OP_W-1:0] ALU_AUI  = 5'd9;
  localparam logic [OP_W-1:0] ALU_JMP  = 5'd10;
  localparam logic [OP_W-1:0] ALU_SRA  = 5'd12;
  localparam logic [OP_W-1:0] ALU_ADDR = 5'd13;

  // funct3 -> ALU op for the base (f7=0) arithmetic group
  function automatic logic [OP_W-1:0] f3_to_op(input logic [2:0] f3);
    logic [OP_W-1:0] op;
    case (f3)
      3'b000:  op = 5'd0;
      3'b001:  op = 5'd6;
      3'b010:  op = 5'd11;
      3'b011:  op = 5'd7;
      3'b100:  op = 5'd4;
      3'b101:  op = 5'd5;
      3'b110:  op = 5'd3;
      default: op = 5'd2;
    endcase
    return op;
  endfunction

  // Register file and bundle state
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  logic            out_valid_q, out_valid_d;
  logic [OP_W-1:0] op_sel_q, op_sel_d;
  logic [XLEN-1:0] rs1_val_q, rs1_val_d;
  logic [XLEN-1:0] rs2_val_q, rs2_val_d;
  logic [XLEN-1:0] rs2_or_imm_q, rs2_or_imm_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [4:0]      rd_q, rd_d;
  logic            reg_we_q, reg_we_d;
  logic            is_load_q, is_load_d;
  logic            is_store_q, is_store_d;
  logic            is_branch_q, is_branch_d;
  logic            is_jal_q, is_jal_d;
  logic            is_jalr_q, is_jalr_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            illegal_q, illegal_d;
  logic [PC_W-1:0] out_pc_q, out_pc_d;
  logic [4:0]      rs1_addr_q, rs1_addr_d;
  logic [4:0]      rs2_addr_q, rs2_addr_d;
  logic            use_rs2_q, use_rs2_d;

  // Instruction fields and immediates
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1_a, rs2_a, rd_a;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  always_comb begin
    opc   = in_instr[6:0];
    rd_a  = in_instr[11:7];
    f3    = in_instr[14:12];
    rs1_a = in_instr[19:15];
    rs2_a = in_instr[24:20];
    f7    = in_instr[31:25];
    imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
             in_instr[11:8], 1'b0};
    imm_u = {in_instr[31:12], 12'b0};
    imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
             in_instr[30:21], 1'b0};
  end

  // Opcode decode; illegal encodings collapse to a neutral bundle at the end
  logic [OP_W-1:0] dec_op;
  logic [31:0]     dec_imm, dec_op2;
  logic            dec_use_rs2, dec_writes, dec_illegal;
  logic            dec_load, dec_store, dec_branch, dec_jal, dec_jalr;

  always_comb begin
    dec_op      = '0;
    dec_imm     = '0;
    dec_op2     = '0;
    dec_use_rs2 = 1'b0;
    dec_writes  = 1'b0;
    dec_illegal = 1'b0;
    dec_load    = 1'b0;
    dec_store   = 1'b0;
    dec_branch  = 1'b0;
    dec_jal     = 1'b0;
    dec_jalr    = 1'b0;
    case (opc)
      OPC_LUI: begin
        dec_op = ALU_LUI; dec_imm = imm_u; dec_op2 = imm_u; dec_writes = 1'b1;
      end
      OPC_AUIPC: begin
        dec_op = ALU_AUI; dec_imm = imm_u; dec_op2 = imm_u; dec_writes = 1'b1;
      end
      OPC_JAL: begin
        dec_op = ALU_JMP; dec_imm = imm_j; dec_op2 = imm_j; dec_writes = 1'b1;
        dec_jal = 1'b1;
      end
      OPC_JALR: begin
        dec_op = ALU_JMP; dec_imm = imm_i; dec_op2 = imm_i; dec_writes = 1'b1;
        dec_jalr = 1'b1;
        dec_illegal = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec_op = ALU_SUB; dec_imm = imm_b; dec_use_rs2 = 1'b1; dec_branch = 1'b1;
        dec_illegal = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        dec_op = ALU_ADDR; dec_imm = imm_i; dec_op2 = imm_i; dec_writes = 1'b1;
        dec_load = 1'b1;
        dec_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        dec_op = ALU_ADDR; dec_imm = imm_s; dec_op2 = imm_s; dec_store = 1'b1;
        dec_illegal = (f3 > 3'b010);
      end
      OPC_OPIMM: begin
        dec_imm = imm_i; dec_op2 = imm_i; dec_writes = 1'b1;
        if (f3 == 3'b001) begin
          dec_op = ALU_SLL;
          dec_illegal = (f7 != F7_BASE);
        end else if (f3 == 3'b101) begin
          dec_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          dec_illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
        end else begin
          dec_op = f3_to_op(f3);
        end
      end
      OPC_OP: begin
        dec_use_rs2 = 1'b1; dec_writes = 1'b1;
        if ((f3 == 3'b000) || (f3 == 3'b101)) begin
          if (f7 == F7_ALT) dec_op = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
          else              dec_op = f3_to_op(f3);
          dec_illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
        end else begin
          dec_op = f3_to_op(f3);
          dec_illegal = (f7 != F7_BASE);
        end
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_op      = '0;
      dec_imm     = '0;
      dec_op2     = '0;
      dec_use_rs2 = 1'b0;
      dec_writes  = 1'b0;
      dec_load    = 1'b0;
      dec_store   = 1'b0;
      dec_branch  = 1'b0;
      dec_jal     = 1'b0;
      dec_jalr    = 1'b0;
    end
  end

  // Register reads with same-cycle writeback bypass
  logic        wb_hit;
  logic [31:0] rs1_rd, rs2_rd;

  always_comb begin
    wb_hit = wb_we && (wb_rd != 5'd0);
    if (rs1_a == 5'd0)                  rs1_rd = '0;
    else if (wb_hit && wb_rd == rs1_a)  rs1_rd = wb_data;
    else                                rs1_rd = regs_q[rs1_a];
    if (rs2_a == 5'd0)                  rs2_rd = '0;
    else if (wb_hit && wb_rd == rs2_a)  rs2_rd = wb_data;
    else                                rs2_rd = regs_q[rs2_a];
  end

  logic accept, fire, stall;

  always_comb begin
    in_ready = !out_valid_q || out_ready;
    accept   = in_valid && in_ready && !flush;
    fire     = out_valid_q && out_ready;
    stall    = out_valid_q && !out_ready;
  end

  // Next-state for the bundle, handshake and register file
  always_comb begin
    regs_d       = regs_q;
    out_valid_d  = out_valid_q;
    op_sel_d     = op_sel_q;
    rs1_val_d    = rs1_val_q;
    rs2_val_d    = rs2_val_q;
    rs2_or_imm_d = rs2_or_imm_q;
    imm_d        = imm_q;
    rd_d         = rd_q;
    reg_we_d     = reg_we_q;
    is_load_d    = is_load_q;
    is_store_d   = is_store_q;
    is_branch_d  = is_branch_q;
    is_jal_d     = is_jal_q;
    is_jalr_d    = is_jalr_q;
    funct3_d     = funct3_q;
    illegal_d    = illegal_q;
    out_pc_d     = out_pc_q;
    rs1_addr_d   = rs1_addr_q;
    rs2_addr_d   = rs2_addr_q;
    use_rs2_d    = use_rs2_q;

    if (wb_hit) regs_d[wb_rd] = wb_data;

    if (accept) begin
      op_sel_d     = dec_op;
      rs1_val_d    = rs1_rd;
      rs2_val_d    = rs2_rd;
      rs2_or_imm_d = dec_use_rs2 ? rs2_rd : dec_op2;
      imm_d        = dec_imm;
      rd_d         = rd_a;
      reg_we_d     = dec_writes && (rd_a != 5'd0);
      is_load_d    = dec_load;
      is_store_d   = dec_store;
      is_branch_d  = dec_branch;
      is_jal_d     = dec_jal;
      is_jalr_d    = dec_jalr;
      funct3_d     = f3;
      illegal_d    = dec_illegal;
      out_pc_d     = in_pc;
      rs1_addr_d   = rs1_a;
      rs2_addr_d   = rs2_a;
      use_rs2_d    = dec_use_rs2;
    end else if (stall && wb_hit) begin
      // A held bundle keeps tracking writebacks to its source registers
      if (wb_rd == rs1_addr_q) rs1_val_d = wb_data;
      if (wb_rd == rs2_addr_q) begin
        rs2_val_d = wb_data;
        if (use_rs2_q) rs2_or_imm_d = wb_data;
      end
    end

    if (flush)       out_valid_d = 1'b0;
    else if (accept) out_valid_d = 1'b1;
    else if (fire)   out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
      out_valid_q  <= 1'b0;
      op_sel_q     <= '0;
      rs1_val_q    <= '0;
      rs2_val_q    <= '0;
      rs2_or_imm_q <= '0;
      imm_q        <= '0;
      rd_q         <= '0;
      reg_we_q     <= 1'b0;
      is_load_q    <= 1'b0;
      is_store_q   <= 1'b0;
      is_branch_q  <= 1'b0;
      is_jal_q     <= 1'b0;
      is_jalr_q    <= 1'b0;
      funct3_q     <= '0;
      illegal_q    <= 1'b0;
      out_pc_q     <= RESET_PC_OUT;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      use_rs2_q    <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= regs_d[i];
      out_valid_q  <= out_valid_d;
      op_sel_q     <= op_sel_d;
      rs1_val_q    <= rs1_val_d;
      rs2_val_q    <= rs2_val_d;
      rs2_or_imm_q <= rs2_or_imm_d;
      imm_q        <= imm_d;
      rd_q         <= rd_d;
      reg_we_q     <= reg_we_d;
      is_load_q    <= is_load_d;
      is_store_q   <= is_store_d;
      is_branch_q  <= is_branch_d;
      is_jal_q     <= is_jal_d;
      is_jalr_q    <= is_jalr_d;
      funct3_q     <= funct3_d;
      illegal_q    <= illegal_d;
      out_pc_q     <= out_pc_d;
      rs1_addr_q   <= rs1_addr_d;
      rs2_addr_q   <= rs2_addr_d;
      use_rs2_q    <= use_rs2_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign op_sel     = op_sel_q;
  assign rs1_val    = rs1_val_q;
  assign rs2_val    = rs2_val_q;
  assign rs2_or_imm = rs2_or_imm_q;
  assign imm        = imm_q;
  assign rd         = rd_q;
  assign reg_we     = reg_we_q;
  assign is_load    = is_load_q;
  assign is_store   = is_store_q;
  assign is_branch  = is_branch_q;
  assign is_jal     = is_jal_q;
  assign is_jalr    = is_jalr_q;
  assign funct3     = funct3_q;
  assign illegal    = illegal_q;
  assign out_pc     = out_pc_q;

endmodule

// File: doc/smol_decode.md
Name: smol_decode

Overview:
Decode/operand-issue stage of smolCore. It sits between fetch and the smolALU execute stage.
- Accepts one fetched RV32I instruction word plus PC over a valid/ready handshake.
- Decodes it into the ALU op_sel encoding and builds the immediate.
- Reads the 32x32 integer register file it owns, with same-cycle writeback bypass.
- Presents a registered, stall-able issue bundle to execute.

Parameters:
PC_W, 32, width of in_pc/out_pc.
RESET_PC_OUT, 0, out_pc value while out_valid=0 after reset.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  fetch presents instruction
in_ready  out  1  decode can accept this cycle
in_instr  in  32  instruction word
in_pc  in  PC_W  instruction PC
flush  in  1  kill held/incoming instruction (branch redirect)
wb_we  in  1  register file write enable
wb_rd  in  5  write address
wb_data  in  32  write data
out_valid  out  1  issue bundle valid
out_ready  in  1  execute accepts bundle
op_sel  out  5  ALU op (0 add,1 sub,2 and,3 or,4 xor,5 srl,6 sll,7 sltu,8 lui,9 auipc,10 jal/jalr,11 slt,12 sra,13 ld/st addr)
rs1_val  out  32  rs1 operand
rs2_val  out  32  rs2 register value (store data, branch compare)
rs2_or_imm  out  32  ALU second operand
imm  out  32  sign-extended immediate (branch/jal target offset)
rd  out  5  destination register
reg_we  out  1  instruction writes rd (0 if rd=x0)
is_load, is_store, is_branch, is_jal, is_jalr  out  1 each  class flags
funct3  out  3  instr[14:12] pass-through
illegal  out  1  unsupported encoding
out_pc  out  PC_W  PC of issued instruction

Behaviour:
- Reset (synchronous): out_valid=0; every bundle output 0; out_pc=RESET_PC_OUT; all 32 registers cleared.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready. Bundle registers load the next cycle, so latency is 1 cycle.
  - Fire when out_valid && out_ready. On fire without accept, out_valid drops to 0.
  - Back-to-back fire+accept gives 1 instruction/cycle.
- Stall: while out_valid && !out_ready, all outputs hold. Exception: rs1_val/rs2_val/rs2_or_imm (register-sourced) update if wb_we writes a matching nonzero register.
- Flush: next cycle out_valid=0, and any same-cycle accept is dropped. Flush beats in_valid. in_ready still follows the formula above.
- Register file:
  - x0 always reads 0; wb writes to x0 are ignored.
  - The write lands at the clock edge.
  - Reads happen in the accept cycle. If wb_we && wb_rd==rs && rs!=0, the read returns wb_data (bypass).
- Immediates: I, S, B, U, J per RV32I, sign-extended. U-imm = {instr[31:12],12'b0}.
- Decode (by opcode):
  - LUI 0110111: op 8, rs2_or_imm=U.
  - AUIPC 0010111: op 9, rs2_or_imm=U.
  - JAL 1101111: op 10, is_jal, imm=J.
  - JALR 1100111 with f3=000: op 10, is_jalr, imm=I.
  - BRANCH 1100011 with f3 in {000,001,100,101,110,111}: op 1, rs2_or_imm=rs2_val, imm=B, reg_we=0.
  - LOAD 0000011 with f3 in {000,001,010,100,101}: op 13, imm=I.
  - STORE 0100011 with f3 in {000,001,010}: op 13, imm=S, reg_we=0.
  - OP-IMM 0010011: f3 000→0, 010→11, 011→7, 100→4, 110→3, 111→2. f3 001 (f7=0000000)→6; f3 101 gives f7 0000000→5, 0100000→12. rs2_or_imm=I (shift amount = instr[24:20]).
  - OP 0110011: f3 000 with f7 0000000→0, 0100000→1; f3 101 with f7 0000000→5, 0100000→12. Other f3 values require f7=0000000 and use the OP-IMM mapping. rs2_or_imm=rs2_val.
  - Anything else: illegal=1, op_sel=0, reg_we=0, all class flags 0. The bundle is still issued with out_valid=1.
- reg_we=1 for LUI/AUIPC/JAL/JALR/LOAD/OP-IMM/OP when rd!=0.

Test Plan:
- Reset, then accept 0x00500093 (addi x1,x0,5) → next cycle out_valid=1, op_sel=0, rs1_val=0, rs2_or_imm=5, rd=1, reg_we=1.
- wb writes x1=7, x2=3, then accept 0x402081B3 (sub x3,x1,x2) → op_sel=1, rs1_val=7, rs2_or_imm=3, rd=3.
- wb_we=1, wb_rd=6, wb_data=0xF0000000 in the same cycle as accepting 0x40335293 (srai x5,x6,3) → rs1_val=0xF0000000 (bypass), op_sel=12, rs2_or_imm=0x403.
- Hold out_ready=0 for 3 cycles after 0x123453B7 (lui x7,0x12345) → in_ready=0, outputs stable, rs2_or_imm=0x12345000. Release → fire, then the next instruction issues the following cycle.
- Accept 0xFFFFFFFF → illegal=1, reg_we=0. Separately, flush asserted together with in_valid → out_valid=0 the next cycle, and the instruction never appears.
- Stall a bundle reading x2 while wb writes x2=0x55 → rs2_val/rs2_or_imm update to 0x55 before fire. A write to x0 leaves all x0 reads at 0.
